pipe_stage_reg: RTL and testbench

- Parametrised, elastic pipeline-boundary register for any stage of the RV32IM 5-stage core (IF/ID, ID/EX, EX/MEM, MEM/WB).
- Carries an arbitrary-width payload with a valid/ready handshake, hazard-unit stall and flush, and configurable bubble insertion.
- Optional 2-entry skid buffer breaks the ready path so that back-pressure from multi-cycle M-extension units (div) is registered.

---
 rtl/rv_pipe_pkg.sv | 38 +++
 rtl/pipe_stage_reg_if.sv | 25 ++
 rtl/pipe_stage_reg.sv | 110 +++++++++++
 tb/tb_pipe_stage_reg.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/rv_pipe_pkg.sv
// rtl/rv_pipe_pkg.sv - shared RV32IM pipeline constants and per-stage payload types
package rv_pipe_pkg;

   localparam int XLEN = 32;
   localparam logic [XLEN-1:0] NOP_INST = 32'h00000013;
   localparam logic [63:0] IF_ID_NOP = {32'h0, NOP_INST};

   typedef struct packed {
      logic [XLEN-1:0] pc;
      logic [XLEN-1:0] inst;
   } if_id_t;

   typedef struct packed {
      logic [XLEN-1:0] pc;
      logic [XLEN-1:0] rs1_val;
      logic [XLEN-1:0] rs2_val;
      logic [XLEN-1:0] imm;
      logic [4:0]      rd;
      logic [3:0]      alu_op;
      logic            mem_we;
      logic            reg_we;
   } id_ex_t;

   typedef struct packed {
      logic [XLEN-1:0] alu_result;
      logic [XLEN-1:0] store_data;
      logic [4:0]      rd;
      logic            mem_we;
      logic            reg_we;
   } ex_mem_t;

   typedef struct packed {
      logic [XLEN-1:0] result;
      logic [4:0]      rd;
      logic            reg_we;
   } mem_wb_t;

endpackage

// File: rtl/pipe_stage_reg_if.sv
// rtl/pipe_stage_reg_if.sv - upstream/downstream valid-ready handshake bundle of a stage register
interface pipe_stage_reg_if
   import rv_pipe_pkg::*;
#(
   parameter int WIDTH = $bits(if_id_t)
) ();

   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] in_data;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] out_data;

   modport slave (
      input  in_valid, in_data, out_ready,
      output in_ready, out_valid, out_data
   );

   modport master (
      output in_valid, in_data, out_ready,
      input  in_ready, out_valid, out_data
   );

endinterface

// File: rtl/pipe_stage_reg.sv
// rtl/pipe_stage_reg.sv - elastic pipeline boundary register with stall, flush and optional skid entry
module pipe_stage_reg
   import rv_pipe_pkg::*;
#(
   parameter int               WIDTH              = $bits(if_id_t),
   parameter logic [WIDTH-1:0] RESET_VAL          = '0,
   parameter logic [WIDTH-1:0] FLUSH_VAL          = WIDTH'(IF_ID_NOP),
   parameter bit               FLUSH_BUBBLE_VALID = 1'b1,
   parameter bit               FLUSH_OVER_STALL   = 1'b0,
   parameter bit               SKID               = 1'b1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             stall_i,
   input  logic             flush_i,
   pipe_stage_reg_if.slave  io,
   output logic [1:0]       occupancy
);

   logic             stall_eff;
   logic             flush_eff;
   logic             accept;
   logic             pop;
   logic             m_valid_q, m_valid_d;
   logic [WIDTH-1:0] m_data_q, m_data_d;
   logic             s_valid_q, s_valid_d;
   logic [WIDTH-1:0] s_data_q;
   logic [1:0]       occ_q;

   assign flush_eff = FLUSH_OVER_STALL ? flush_i : (flush_i & ~stall_i);
   assign stall_eff = FLUSH_OVER_STALL ? (stall_i & ~flush_i) : stall_i;

   assign io.out_data  = m_data_q;
   assign io.out_valid = m_valid_q & ~stall_eff;
   assign occupancy    = occ_q;

   assign accept = io.in_valid & io.in_ready;
   assign pop    = io.out_valid & io.out_ready;

   // in_ready already excludes stall and flush, so accept implies a normal cycle.
   always_comb begin
      m_data_d  = m_data_q;
      m_valid_d = m_valid_q;
      if (flush_eff) begin
         m_data_d  = FLUSH_VAL;
         m_valid_d = FLUSH_BUBBLE_VALID;
      end else if (pop) begin
         if (accept) begin
            m_data_d  = io.in_data;
            m_valid_d = 1'b1;
         end else begin
            m_data_d  = s_data_q;
            m_valid_d = s_valid_q;
         end
      end else if (accept && !m_valid_q) begin
         m_data_d  = io.in_data;
         m_valid_d = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         m_data_q  <= RESET_VAL;
         m_valid_q <= 1'b0;
         occ_q     <= 2'd0;
      end else begin
         m_data_q  <= m_data_d;
         m_valid_q <= m_valid_d;
         occ_q     <= {1'b0, m_valid_d} + {1'b0, s_valid_d};
      end
   end

   generate
      if (SKID) begin : g_skid
         logic [WIDTH-1:0] s_data_d;

         // Ready depends only on registered skid state, not on out_ready.
         assign io.in_ready = ~s_valid_q & ~stall_eff & ~flush_eff;

         always_comb begin
            s_data_d  = s_data_q;
            s_valid_d = s_valid_q;
            if (flush_eff) begin
               s_valid_d = 1'b0;
            end else if (pop && !accept) begin
               s_valid_d = 1'b0;
            end else if (accept && !pop && m_valid_q) begin
               s_data_d  = io.in_data;
               s_valid_d = 1'b1;
            end
         end

         always_ff @(posedge clk) begin
            if (!rst) begin
               s_data_q  <= RESET_VAL;
               s_valid_q <= 1'b0;
            end else begin
               s_data_q  <= s_data_d;
               s_valid_q <= s_valid_d;
            end
         end
      end else begin : g_no_skid
         assign io.in_ready = (~m_valid_q | io.out_ready) & ~stall_eff & ~flush_eff;
         assign s_valid_q   = 1'b0;
         assign s_valid_d   = 1'b0;
         assign s_data_q    = RESET_VAL;
      end
   endgenerate

endmodule

// File: tb/tb_pipe_stage_reg.sv
// tb/tb_pipe_stage_reg.sv - directed scoreboard bench for pipe_stage_reg in skid, flush-priority and no-skid builds
module tb_pipe_stage_reg;
   import rv_pipe_pkg::*;

   localparam int W = 64;
   localparam logic [W-1:0] FV = {32'h0, 32'h00000013};

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   logic a_stall, a_flush, b_stall, b_flush, c_stall, c_flush;
   logic [1:0] a_occ, b_occ, c_occ;

   pipe_stage_reg_if #(.WIDTH(W)) a_if ();
   pipe_stage_reg_if #(.WIDTH(W)) b_if ();
   pipe_stage_reg_if #(.WIDTH(W)) c_if ();

   pipe_stage_reg #(.WIDTH(W), .SKID(1'b1), .FLUSH_OVER_STALL(1'b0)) dut_a (
      .clk(clk), .rst(rst), .stall_i(a_stall), .flush_i(a_flush), .io(a_if.slave), .occupancy(a_occ));
   pipe_stage_reg #(.WIDTH(W), .SKID(1'b1), .FLUSH_OVER_STALL(1'b1)) dut_b (
      .clk(clk), .rst(rst), .stall_i(b_stall), .flush_i(b_flush), .io(b_if.slave), .occupancy(b_occ));
   pipe_stage_reg #(.WIDTH(W), .SKID(1'b0), .FLUSH_OVER_STALL(1'b0)) dut_c (
      .clk(clk), .rst(rst), .stall_i(c_stall), .flush_i(c_flush), .io(c_if.slave), .occupancy(c_occ));

   int checks = 0;
   int errors = 0;
   int c_pops = 0;
   logic [W-1:0] qa[$];
   logic [W-1:0] qc[$];

   task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Runs at the negedge: pop compares first, then flush/accept update the expectation queues.
   task automatic sb_update();
      if (a_if.out_valid && a_if.out_ready) begin
         chk("a_sb_nonempty", W'(qa.size() != 0), 1);
         if (qa.size() != 0) chk("a_sb_data", a_if.out_data, qa.pop_front());
      end
      if (a_flush && !a_stall) begin
         qa.delete();
         qa.push_back(FV);
      end else if (a_if.in_valid && a_if.in_ready) begin
         qa.push_back(a_if.in_data);
      end
      if (c_if.out_valid && c_if.out_ready) begin
         c_pops++;
         chk("c_sb_nonempty", W'(qc.size() != 0), 1);
         if (qc.size() != 0) chk("c_sb_data", c_if.out_data, qc.pop_front());
      end
      if (c_if.in_valid && c_if.in_ready) qc.push_back(c_if.in_data);
   endtask

   task automatic step();
      sb_update();
      @(posedge clk);
      #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog timeout");
      $fatal(1, "timeout");
   end

   initial begin
      logic acc;
      logic [W-1:0] nxt;
      int guard;

      rst = 1'b0;
      {a_stall, a_flush, b_stall, b_flush, c_stall, c_flush} = '0;
      a_if.in_valid = 1'b1; a_if.in_data = 64'hDEAD; a_if.out_ready = 1'b1;
      b_if.in_valid = 1'b0; b_if.in_data = '0;       b_if.out_ready = 1'b1;
      c_if.in_valid = 1'b0; c_if.in_data = '0;       c_if.out_ready = 1'b1;

      repeat (2) begin
         @(posedge clk);
         @(negedge clk);
         chk("rst_out_valid", a_if.out_valid, 0);
         chk("rst_out_data", a_if.out_data, 0);
         chk("rst_occupancy", a_occ, 0);
      end
      chk("rst_c_occupancy", c_occ, 0);
      rst = 1'b1;
      a_if.in_valid = 1'b0;
      @(posedge clk); #1;

      // first beat after reset: one cycle of latency
      a_if.in_valid = 1'b1; a_if.in_data = {32'hCAFE0000, 32'h1};
      @(negedge clk);
      chk("lat_in_ready", a_if.in_ready, 1);
      chk("lat_empty", a_if.out_valid, 0);
      step();
      a_if.in_valid = 1'b0;
      @(negedge clk);
      chk("lat_out_valid", a_if.out_valid, 1);
      chk("lat_out_data", a_if.out_data, {32'hCAFE0000, 32'h1});
      step();

      // streaming at full rate
      for (int i = 0; i < 8; i++) begin
         a_if.in_valid = 1'b1;
         a_if.in_data  = {32'h1000_0000 + 32'(i), 32'h100 + 32'(i)};
         @(negedge clk);
         chk("stream_in_ready", a_if.in_ready, 1);
         chk("stream_out_valid", a_if.out_valid, W'(i != 0));
         step();
      end
      a_if.in_valid = 1'b0;
      @(negedge clk);
      chk("stream_last_valid", a_if.out_valid, 1);
      step();
      @(negedge clk);
      chk("stream_drained", W'(qa.size()), 0);
      chk("stream_idle", a_if.out_valid, 0);
      step();

      // back-pressure fills main and skid, third beat stalls upstream
      a_if.out_ready = 1'b0;
      a_if.in_valid = 1'b1; a_if.in_data = 64'hA;
      @(negedge clk); chk("bp_rdy_a", a_if.in_ready, 1); step();
      a_if.in_data = 64'hB;
      @(negedge clk); chk("bp_rdy_b", a_if.in_ready, 1); chk("bp_occ1", a_occ, 1); step();
      a_if.in_data = 64'hC;
      @(negedge clk);
      chk("bp_rdy_full", a_if.in_ready, 0);
      chk("bp_occ2", a_occ, 2);
      chk("bp_head", a_if.out_data, 64'hA);
      step();
      a_if.out_ready = 1'b1;
      guard = 0;
      while ((qa.size() != 0 || a_if.in_valid) && guard < 10) begin
         @(negedge clk);
         acc = a_if.in_valid & a_if.in_ready;
         step();
         if (acc) a_if.in_valid = 1'b0;
         guard++;
      end
      chk("bp_c_accepted", a_if.in_valid, 0);
      chk("bp_drained", W'(qa.size()), 0);

      // flush while holding two beats
      a_if.out_ready = 1'b0;
      a_if.in_valid = 1'b1; a_if.in_data = 64'hA;
      @(negedge clk); step();
      a_if.in_data = 64'hB;
      @(negedge clk); step();
      a_flush = 1'b1; a_if.in_data = 64'hD;
      @(negedge clk);
      chk("flush_in_ready", a_if.in_ready, 0);
      step();
      a_flush = 1'b0; a_if.in_valid = 1'b0;
      @(negedge clk);
      chk("flush_out_valid", a_if.out_valid, 1);
      chk("flush_out_data", a_if.out_data, FV);
      chk("flush_occ", a_occ, 1);
      step();
      a_if.out_ready = 1'b1;
      @(negedge clk); step();
      @(negedge clk);
      chk("flush_after_valid", a_if.out_valid, 0);
      chk("flush_drained", W'(qa.size()), 0);
      step();

      // stall+flush collision, stall wins
      a_if.out_ready = 1'b0;
      a_if.in_valid = 1'b1; a_if.in_data = 64'hA1;
      @(negedge clk); step();
      a_if.in_valid = 1'b0; a_stall = 1'b1; a_flush = 1'b1;
      @(negedge clk);
      chk("col0_out_valid", a_if.out_valid, 0);
      chk("col0_in_ready", a_if.in_ready, 0);
      step();
      a_stall = 1'b0; a_flush = 1'b0;
      @(negedge clk);
      chk("col0_held_valid", a_if.out_valid, 1);
      chk("col0_held_data", a_if.out_data, 64'hA1);
      chk("col0_occ", a_occ, 1);
      step();
      a_if.out_ready = 1'b1;
      @(negedge clk); step();
      @(negedge clk);
      chk("col0_drained", W'(qa.size()), 0);
      step();

      // stall+flush collision, flush wins
      b_if.out_ready = 1'b0;
      b_if.in_valid = 1'b1; b_if.in_data = 64'hB1;
      @(negedge clk); step();
      b_if.in_valid = 1'b0; b_stall = 1'b1; b_flush = 1'b1;
      @(negedge clk);
      chk("col1_in_ready", b_if.in_ready, 0);
      step();
      b_stall = 1'b0; b_flush = 1'b0;
      @(negedge clk);
      chk("col1_out_valid", b_if.out_valid, 1);
      chk("col1_out_data", b_if.out_data, FV);
      chk("col1_occ", b_occ, 1);
      step();

      // no-skid build: combinational ready, one transfer per out_ready-high cycle
      c_if.out_ready = 1'b0;
      c_if.in_valid = 1'b1; nxt = 64'h5000; c_if.in_data = nxt;
      @(negedge clk); chk("c_rdy_empty", c_if.in_ready, 1); step();
      nxt = nxt + 1; c_if.in_data = nxt;
      @(negedge clk);
      chk("c_rdy_full", c_if.in_ready, 0);
      chk("c_occ_full", c_occ, 1);
      step();
      c_pops = 0;
      for (int k = 0; k < 8; k++) begin
         c_if.out_ready = (k % 2 == 0);
         @(negedge clk);
         chk("c_rdy_follow", c_if.in_ready, W'(k % 2 == 0));
         acc = c_if.in_valid & c_if.in_ready;
         step();
         if (acc) begin
            nxt = nxt + 1;
            c_if.in_data = nxt;
         end
      end
      chk("c_pop_count", W'(c_pops), 4);
      c_if.in_valid = 1'b0; c_if.out_ready = 1'b1;
      @(negedge clk); step();
      @(negedge clk);
      chk("c_drained", W'(qc.size()), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
